// File: rtl/sec_timer_scheduler.sv
// Multi-channel seconds countdown scheduler sharing one prescaled 1 Hz tick.
// Optional periodic auto-reload per channel when STS_AUTORELOAD_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | no timer loaded, remain 0, may accept a grant
// S_RUN   | counting down one second per tick
// S_PAUSE | held by pause, ticks are dropped
// S_DONE  | expired naturally, remain 0, may accept a grant
module sec_timer_scheduler #(
    parameter int CLK_FREQ = 100000000,
    parameter int NCH      = 4,
    parameter int CW       = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    req_valid_i,
    input  logic [NCH*CW-1:0] req_secs_i,
    output logic [NCH-1:0]    req_ready_o,
    input  logic [NCH-1:0]    pause_i,
    input  logic [NCH-1:0]    cancel_i,
`ifdef STS_AUTORELOAD_EN
    input  logic [NCH-1:0]    reload_en_i,
`endif
    output logic [NCH-1:0]    busy_o,
    output logic [NCH-1:0]    done_o,
    output logic [NCH*CW-1:0] remain_o,
    output logic              tick_1hz_o
);
    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_FREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d;
    logic [IW-1:0] ptr_q, ptr_d;
    state_e        state_q  [NCH];
    state_e        state_d  [NCH];
    logic [CW-1:0] remain_q [NCH];
    logic [CW-1:0] remain_d [NCH];
    logic [NCH-1:0] done_q, done_d;
    logic [NCH-1:0] eligible, grant;
    logic          found;
    int            idx;
`ifdef STS_AUTORELOAD_EN
    logic [CW-1:0] reload_q [NCH];
    logic [CW-1:0] reload_d [NCH];
`endif

    always_comb begin
        pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
        tick_d = (pre_q == PRE_LAST);
    end

    // Round-robin search beginning at ptr_q; first eligible channel wins.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NCH; i++) begin
            eligible[i] = req_valid_i[i] & ~cancel_i[i] &
                          ((state_q[i] == S_IDLE) || (state_q[i] == S_DONE));
        end
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(ptr_q) + k) % NCH;
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_d      = IW'((idx + 1) % NCH);
            end
        end
    end

    assign req_ready_o = grant & {NCH{reset}};

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i]  = state_q[i];
            remain_d[i] = remain_q[i];
            done_d[i]   = 1'b0;
`ifdef STS_AUTORELOAD_EN
            reload_d[i] = reload_q[i];
`endif
            if (cancel_i[i]) begin
                state_d[i]  = S_IDLE;
                remain_d[i] = '0;
            end else if (grant[i]) begin
                remain_d[i] = req_secs_i[i*CW +: CW];
`ifdef STS_AUTORELOAD_EN
                reload_d[i] = req_secs_i[i*CW +: CW];
`endif
                if (req_secs_i[i*CW +: CW] == '0) begin
                    state_d[i] = S_DONE;
                    done_d[i]  = 1'b1;
                end else begin
                    state_d[i] = S_RUN;
                end
            end else begin
                case (state_q[i])
                    S_RUN: begin
                        if (pause_i[i]) begin
                            state_d[i] = S_PAUSE;
                        end else if (tick_q) begin
                            if (remain_q[i] == CW'(1)) begin
                                done_d[i] = 1'b1;
`ifdef STS_AUTORELOAD_EN
                                if (reload_en_i[i] && (reload_q[i] != '0)) begin
                                    remain_d[i] = reload_q[i];
                                end else begin
                                    remain_d[i] = '0;
                                    state_d[i]  = S_DONE;
                                end
`else
                                remain_d[i] = '0;
                                state_d[i]  = S_DONE;
`endif
                            end else if (remain_q[i] != '0) begin
                                remain_d[i] = remain_q[i] - CW'(1);
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (!pause_i[i]) begin
                            state_d[i] = S_RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
            ptr_q  <= '0;
            done_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= S_IDLE;
                remain_q[i] <= '0;
`ifdef STS_AUTORELOAD_EN
                reload_q[i] <= '0;
`endif
            end
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
            ptr_q  <= ptr_d;
            done_q <= done_d;
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= state_d[i];
                remain_q[i] <= remain_d[i];
`ifdef STS_AUTORELOAD_EN
                reload_q[i] <= reload_d[i];
`endif
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            busy_o[i]               = (state_q[i] == S_RUN) || (state_q[i] == S_PAUSE);
            remain_o[i*CW +: CW]    = remain_q[i];
        end
    end

    assign done_o     = done_q;
    assign tick_1hz_o = tick_q;

endmodule

// File: tb/tb_sec_timer_scheduler.sv
// Scoreboard bench for sec_timer_scheduler (CLK_FREQ=10, NCH=4, CW=12).
module tb_sec_timer_scheduler;
    localparam int CLK_FREQ = 10;
    localparam int NCH      = 4;
    localparam int CW       = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NCH-1:0]    req_valid = '0;
    logic [NCH*CW-1:0] req_secs = '0;
    logic [NCH-1:0]    req_ready;
    logic [NCH-1:0]    pause = '0;
    logic [NCH-1:0]    cancel = '0;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    done;
    logic [NCH*CW-1:0] remain;
    logic              tick;
`ifdef STS_AUTORELOAD_EN
    logic [NCH-1:0]    reload_en = '0;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int ch;
        int rem;
        bit dn;
    } exp_t;
    exp_t sb[$];
    int   gq[$];

    sec_timer_scheduler #(.CLK_FREQ(CLK_FREQ), .NCH(NCH), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_secs_i  (req_secs),
        .req_ready_o (req_ready),
        .pause_i     (pause),
        .cancel_i    (cancel),
`ifdef STS_AUTORELOAD_EN
        .reload_en_i (reload_en),
`endif
        .busy_o      (busy),
        .done_o      (done),
        .remain_o    (remain),
        .tick_1hz_o  (tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Advance past the next tick edge; returns at the negedge right after it.
    task automatic wait_tick();
        int n = 0;
        while (tick !== 1'b1 && n < 3 * CLK_FREQ) begin
            @(negedge clk);
            n++;
        end
        if (tick !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL wait_tick: tick=%b after %0d cycles, required 1", tick, n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit exp_tick;
        req_valid = '1;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (req_ready !== '0 || busy !== '0 || done !== '0 || remain !== '0 || tick !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: ready=%b busy=%b done=%b remain=%h tick=%b, required all 0",
                     req_ready, busy, done, remain, tick);
        end
        req_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 35; n++) begin
            @(negedge clk);
            exp_tick = ((cyc % CLK_FREQ) == 0) && (cyc != 0);
            tests++;
            if (tick !== exp_tick) begin
                fails++;
                $display("FAIL tick_period: cycle %0d tick=%b, required %b", cyc, tick, exp_tick);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_g;
        wait_tick();
        req_secs  = {NCH{12'd2}};
        req_valid = 4'b1111;
        gq = {1, 2, 4, 8, 0};
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_g = gq.pop_front();
            tests++;
            if (req_ready !== exp_g[NCH-1:0]) begin
                fails++;
                $display("FAIL rr_grant[%0d]: ready=%b, required %b", k, req_ready, exp_g[NCH-1:0]);
            end
            @(negedge clk);
        end
        req_valid = '0;
        wait_tick();
        wait_tick();
        tests++;
        if (done !== 4'b1111 || busy !== 4'b0000 || remain !== '0) begin
            fails++;
            $display("FAIL rr_expire: done=%b busy=%b remain=%h, required 1111 0000 0", done, busy, remain);
        end
        @(negedge clk);
        tests++;
        if (done !== 4'b0000) begin
            fails++;
            $display("FAIL rr_done_width: done=%b, required 0000", done);
        end
    endtask

    task automatic test_single();
        exp_t e;
        sb.push_back('{1, 3, 1'b0});
        sb.push_back('{1, 2, 1'b0});
        sb.push_back('{1, 1, 1'b0});
        sb.push_back('{1, 0, 1'b1});
        req_secs[1*CW +: CW] = 12'd3;
        req_valid = 4'b0010;
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL single_grant: ready=%b, required 0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        for (int s = 0; s < 4; s++) begin
            if (s > 0) wait_tick();
            e = sb.pop_front();
            tests++;
            if (remain[e.ch*CW +: CW] !== CW'(e.rem) || done[e.ch] !== e.dn || busy[e.ch] !== !e.dn) begin
                fails++;
                $display("FAIL single_step[%0d]: remain=%0d done=%b busy=%b, required %0d %b %b",
                         s, remain[e.ch*CW +: CW], done[e.ch], busy[e.ch], e.rem, e.dn, !e.dn);
            end
        end
        @(negedge clk);
        tests++;
        if (done[1] !== 1'b0 || remain[1*CW +: CW] !== '0) begin
            fails++;
            $display("FAIL single_hold: done=%b remain=%0d, required 0 0", done[1], remain[1*CW +: CW]);
        end
    endtask

    task automatic test_pause();
        exp_t e;
        sb.push_back('{0, 4, 1'b0});
        sb.push_back('{0, 3, 1'b0});
        sb.push_back('{0, 3, 1'b0});
        sb.push_back('{0, 3, 1'b0});
        sb.push_back('{0, 2, 1'b0});
        sb.push_back('{0, 1, 1'b0});
        sb.push_back('{0, 0, 1'b1});
        req_secs[0 +: CW] = 12'd4;
        req_valid = 4'b0001;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL pause_grant: ready=%b, required 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        for (int s = 0; s < 7; s++) begin
            if (s > 0) wait_tick();
            e = sb.pop_front();
            tests++;
            if (remain[e.ch*CW +: CW] !== CW'(e.rem) || done[e.ch] !== e.dn || busy[e.ch] !== !e.dn) begin
                fails++;
                $display("FAIL pause_step[%0d]: remain=%0d done=%b busy=%b, required %0d %b %b",
                         s, remain[e.ch*CW +: CW], done[e.ch], busy[e.ch], e.rem, e.dn, !e.dn);
            end
            if (s == 1) pause = 4'b0001;
            if (s == 3) pause = 4'b0000;
        end
    endtask

    task automatic test_cancel();
        int n = 0;
        req_secs[2*CW +: CW] = 12'd2;
        req_valid = 4'b0100;
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL cancel_grant: ready=%b, required 0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        wait_tick();
        while (tick !== 1'b1 && n < 3 * CLK_FREQ) begin
            @(negedge clk);
            n++;
        end
        cancel = 4'b0100;
        @(negedge clk);
        cancel = '0;
        tests++;
        if (done[2] !== 1'b0 || busy[2] !== 1'b0 || remain[2*CW +: CW] !== '0) begin
            fails++;
            $display("FAIL cancel_at_tick: done=%b busy=%b remain=%0d, required 0 0 0",
                     done[2], busy[2], remain[2*CW +: CW]);
        end
        @(negedge clk);
        tests++;
        if (done[2] !== 1'b0) begin
            fails++;
            $display("FAIL cancel_no_done: done=%b, required 0", done[2]);
        end
        req_secs[2*CW +: CW] = 12'd7;
        req_valid = 4'b0100;
        cancel    = 4'b0100;
        #1;
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL cancel_blocks_grant: ready=%b, required 0000", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        cancel    = '0;
        tests++;
        if (busy[2] !== 1'b0 || remain[2*CW +: CW] !== '0) begin
            fails++;
            $display("FAIL cancel_no_load: busy=%b remain=%0d, required 0 0", busy[2], remain[2*CW +: CW]);
        end
    endtask

    task automatic test_zero();
        req_secs[3*CW +: CW] = 12'd0;
        req_valid = 4'b1000;
        #1;
        tests++;
        if (req_ready !== 4'b1000) begin
            fails++;
            $display("FAIL zero_grant: ready=%b, required 1000", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        tests++;
        if (done[3] !== 1'b1 || busy[3] !== 1'b0 || remain[3*CW +: CW] !== '0) begin
            fails++;
            $display("FAIL zero_done: done=%b busy=%b remain=%0d, required 1 0 0",
                     done[3], busy[3], remain[3*CW +: CW]);
        end
        @(negedge clk);
        tests++;
        if (done[3] !== 1'b0) begin
            fails++;
            $display("FAIL zero_done_width: done=%b, required 0", done[3]);
        end
    endtask

    task automatic test_grant_on_tick();
        int n = 0;
        while (tick !== 1'b1 && n < 3 * CLK_FREQ) begin
            @(negedge clk);
            n++;
        end
        req_secs[1*CW +: CW] = 12'd5;
        req_valid = 4'b0010;
        #1;
        tests++;
        if (req_ready !== 4'b0010 || tick !== 1'b1) begin
            fails++;
            $display("FAIL tick_grant: ready=%b tick=%b, required 0010 1", req_ready, tick);
        end
        @(negedge clk);
        req_valid = '0;
        tests++;
        if (remain[1*CW +: CW] !== 12'd5) begin
            fails++;
            $display("FAIL tick_grant_load: remain=%0d, required 5", remain[1*CW +: CW]);
        end
        cancel = 4'b0010;
        @(negedge clk);
        cancel = '0;
    endtask

    task automatic test_back_to_back();
        int exp_g;
        req_secs[0 +: CW]    = 12'd1;
        req_secs[3*CW +: CW] = 12'd1;
        req_valid = 4'b1001;
        gq = {8, 1};
        for (int k = 0; k < 2; k++) begin
            #1;
            exp_g = gq.pop_front();
            tests++;
            if (req_ready !== exp_g[NCH-1:0]) begin
                fails++;
                $display("FAIL b2b_grant[%0d]: ready=%b, required %b", k, req_ready, exp_g[NCH-1:0]);
            end
            @(negedge clk);
        end
        req_valid = '0;
        tests++;
        if (busy !== 4'b1001) begin
            fails++;
            $display("FAIL b2b_busy: busy=%b, required 1001", busy);
        end
        cancel = 4'b1111;
        @(negedge clk);
        cancel = '0;
    endtask

`ifdef STS_AUTORELOAD_EN
    task automatic test_autoreload();
        reload_en = 4'b1000;
        req_secs[3*CW +: CW] = 12'd2;
        req_valid = 4'b1000;
        #1;
        tests++;
        if (req_ready !== 4'b1000) begin
            fails++;
            $display("FAIL reload_grant: ready=%b, required 1000", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        for (int r = 0; r < 3; r++) begin
            wait_tick();
            tests++;
            if (done[3] !== 1'b0 || busy[3] !== 1'b1 || remain[3*CW +: CW] !== 12'd1) begin
                fails++;
                $display("FAIL reload_mid[%0d]: done=%b busy=%b remain=%0d, required 0 1 1",
                         r, done[3], busy[3], remain[3*CW +: CW]);
            end
            wait_tick();
            tests++;
            if (done[3] !== 1'b1 || busy[3] !== 1'b1 || remain[3*CW +: CW] !== 12'd2) begin
                fails++;
                $display("FAIL reload_expire[%0d]: done=%b busy=%b remain=%0d, required 1 1 2",
                         r, done[3], busy[3], remain[3*CW +: CW]);
            end
        end
        cancel = 4'b1000;
        @(negedge clk);
        cancel = '0;
        req_secs[3*CW +: CW] = 12'd0;
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = '0;
        tests++;
        if (done[3] !== 1'b1 || busy[3] !== 1'b0) begin
            fails++;
            $display("FAIL reload_zero: done=%b busy=%b, required 1 0", done[3], busy[3]);
        end
        reload_en = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_pause();
        test_cancel();
        test_zero();
        test_grant_on_tick();
        test_back_to_back();
`ifdef STS_AUTORELOAD_EN
        test_autoreload();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
